// File: rtl/batch_filter_engine.sv
// batch_filter_engine: accepts transactions carrying read/write dependency
// bitmaps, drops any that conflict with locks held externally or taken earlier
// in the current batch, and forwards the rest. A batch closes automatically at
// MAX_BATCH_SIZE forwarded transactions, or on request through batch_flush.
// Optional build macro: FILTER_CONFLICT_STATS_EN adds the raw_hits, waw_hits
// and war_hits counters, which count dropped transactions by conflict type.
module batch_filter_engine #(
  parameter int MAX_DEPENDENCIES = 1024,
  parameter int MAX_BATCH_SIZE   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [63:0]                 s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [63:0]                 m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0] ext_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0] ext_write_dependencies,
  input  logic                        batch_flush,
  output logic                        batch_closed,
  output logic [7:0]                  batch_size,
`ifdef FILTER_CONFLICT_STATS_EN
  output logic [31:0]                 raw_hits,
  output logic [31:0]                 waw_hits,
  output logic [31:0]                 war_hits,
`endif
  output logic [31:0]                 filter_hits
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;
  localparam logic [1:0] CLOSE  = 2'd3;

  localparam logic [7:0]  BATCH_LIMIT = 8'(MAX_BATCH_SIZE);
  localparam logic [31:0] COUNT_MAX   = 32'hFFFF_FFFF;

  logic [1:0]                  state;
  logic                        flush_pending;
  logic [63:0]                 in_id;
  logic [MAX_DEPENDENCIES-1:0] in_rd;
  logic [MAX_DEPENDENCIES-1:0] in_wr;
  logic [MAX_DEPENDENCIES-1:0] acc_rd;
  logic [MAX_DEPENDENCIES-1:0] acc_wr;
  logic [7:0]                  batch_count;

  logic [MAX_DEPENDENCIES-1:0] eff_rd;
  logic [MAX_DEPENDENCIES-1:0] eff_wr;
  logic                        raw;
  logic                        waw;
  logic                        war;
  logic                        conflict;

  // A new transaction is only taken while idle with no close request waiting.
  assign s_axis_tready = (state == IDLE) && !flush_pending;

  // Classify the latched transaction against everything locked so far.
  always_comb begin
    eff_rd   = acc_rd | ext_read_dependencies;
    eff_wr   = acc_wr | ext_write_dependencies;
    raw      = |(in_rd & eff_wr);
    waw      = |(in_wr & eff_wr);
    war      = |(in_wr & eff_rd);
    conflict = raw || waw || war;
  end

  // Main controller: accept, check, forward, and close batches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                           <= IDLE;
      flush_pending                   <= 1'b0;
      in_id                           <= '0;
      in_rd                           <= '0;
      in_wr                           <= '0;
      acc_rd                          <= '0;
      acc_wr                          <= '0;
      batch_count                     <= '0;
      m_axis_tvalid                   <= 1'b0;
      m_axis_tdata_owner_programID    <= '0;
      m_axis_tdata_read_dependencies  <= '0;
      m_axis_tdata_write_dependencies <= '0;
      batch_closed                    <= 1'b0;
      batch_size                      <= '0;
      filter_hits                     <= '0;
    end else begin
      batch_closed <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_pending) begin
            if (batch_count != 8'd0) begin
              state <= CLOSE;
            end else begin
              flush_pending <= 1'b0;
            end
          end else if (s_axis_tvalid) begin
            in_id <= s_axis_tdata_owner_programID;
            in_rd <= s_axis_tdata_read_dependencies;
            in_wr <= s_axis_tdata_write_dependencies;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (conflict) begin
            if (filter_hits != COUNT_MAX) begin
              filter_hits <= filter_hits + 32'd1;
            end
            state <= IDLE;
          end else begin
            m_axis_tvalid                   <= 1'b1;
            m_axis_tdata_owner_programID    <= in_id;
            m_axis_tdata_read_dependencies  <= in_rd;
            m_axis_tdata_write_dependencies <= in_wr;
            acc_rd                          <= acc_rd | in_rd;
            acc_wr                          <= acc_wr | in_wr;
            batch_count                     <= batch_count + 8'd1;
            state                           <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            state         <= (batch_count == BATCH_LIMIT) ? CLOSE : IDLE;
          end
        end
        CLOSE: begin
          batch_closed  <= 1'b1;
          batch_size    <= batch_count;
          batch_count   <= '0;
          acc_rd        <= '0;
          acc_wr        <= '0;
          flush_pending <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A flush request is sticky and takes priority over any clear above.
      if (batch_flush) begin
        flush_pending <= 1'b1;
      end
    end
  end

`ifdef FILTER_CONFLICT_STATS_EN
  // Per-type drop counters; one drop can bump several of them at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_hits <= '0;
      waw_hits <= '0;
      war_hits <= '0;
    end else if (state == CHECK && conflict) begin
      if (raw && raw_hits != COUNT_MAX) raw_hits <= raw_hits + 32'd1;
      if (waw && waw_hits != COUNT_MAX) waw_hits <= waw_hits + 32'd1;
      if (war && war_hits != COUNT_MAX) war_hits <= war_hits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_batch_filter_engine.sv
// Testbench for batch_filter_engine with 8-bit dependency maps and batches of
// two. A driver issues transactions and pushes predicted results into queues;
// a monitor pops and compares whenever the DUT forwards a transaction or
// closes a batch.
module tb_batch_filter_engine;

  localparam int DEPS  = 8;
  localparam int BATCH = 2;

  typedef struct {
    logic [63:0]     id;
    logic [DEPS-1:0] rd;
    logic [DEPS-1:0] wr;
  } txn_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [63:0]     s_axis_tdata_owner_programID;
  logic [DEPS-1:0] s_axis_tdata_read_dependencies;
  logic [DEPS-1:0] s_axis_tdata_write_dependencies;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [63:0]     m_axis_tdata_owner_programID;
  logic [DEPS-1:0] m_axis_tdata_read_dependencies;
  logic [DEPS-1:0] m_axis_tdata_write_dependencies;
  logic [DEPS-1:0] ext_read_dependencies;
  logic [DEPS-1:0] ext_write_dependencies;
  logic            batch_flush;
  logic            batch_closed;
  logic [7:0]      batch_size;
  logic [31:0]     filter_hits;
`ifdef FILTER_CONFLICT_STATS_EN
  logic [31:0]     raw_hits;
  logic [31:0]     waw_hits;
  logic [31:0]     war_hits;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the accepted transactions of the open batch, expected
  // outputs, expected batch sizes, and expected drop counts.
  txn_t        batch_q[$];
  txn_t        exp_q[$];
  int          close_q[$];
  int unsigned exp_hits = 0;
  int unsigned exp_raw  = 0;
  int unsigned exp_waw  = 0;
  int unsigned exp_war  = 0;

  logic hold_ready = 1'b0;
  logic rand_ready = 1'b0;

  always #5 clk = ~clk;

  batch_filter_engine #(
    .MAX_DEPENDENCIES(DEPS),
    .MAX_BATCH_SIZE  (BATCH)
  ) dut (
    .clk                            (clk),
    .rst                            (rst),
    .s_axis_tvalid                  (s_axis_tvalid),
    .s_axis_tready                  (s_axis_tready),
    .s_axis_tdata_owner_programID   (s_axis_tdata_owner_programID),
    .s_axis_tdata_read_dependencies (s_axis_tdata_read_dependencies),
    .s_axis_tdata_write_dependencies(s_axis_tdata_write_dependencies),
    .m_axis_tvalid                  (m_axis_tvalid),
    .m_axis_tready                  (m_axis_tready),
    .m_axis_tdata_owner_programID   (m_axis_tdata_owner_programID),
    .m_axis_tdata_read_dependencies (m_axis_tdata_read_dependencies),
    .m_axis_tdata_write_dependencies(m_axis_tdata_write_dependencies),
    .ext_read_dependencies          (ext_read_dependencies),
    .ext_write_dependencies         (ext_write_dependencies),
    .batch_flush                    (batch_flush),
    .batch_closed                   (batch_closed),
    .batch_size                     (batch_size),
`ifdef FILTER_CONFLICT_STATS_EN
    .raw_hits                       (raw_hits),
    .waw_hits                       (waw_hits),
    .war_hits                       (war_hits),
`endif
    .filter_hits                    (filter_hits)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: got no response within bound, required a response", name);
  endtask

  function automatic void clearModel();
    batch_q.delete();
    exp_q.delete();
    close_q.delete();
    exp_hits = 0;
    exp_raw  = 0;
    exp_waw  = 0;
    exp_war  = 0;
  endfunction

  // A transaction is dropped if it clashes with external locks or with any
  // single earlier transaction of the same batch; otherwise it joins the batch.
  function automatic void modelTxn(input logic [63:0] id, input logic [DEPS-1:0] rd,
                                   input logic [DEPS-1:0] wr);
    bit   raw_c, waw_c, war_c;
    txn_t t;
    raw_c = (rd & ext_write_dependencies) != 0;
    waw_c = (wr & ext_write_dependencies) != 0;
    war_c = (wr & ext_read_dependencies) != 0;
    foreach (batch_q[i]) begin
      if ((rd & batch_q[i].wr) != 0) raw_c = 1'b1;
      if ((wr & batch_q[i].wr) != 0) waw_c = 1'b1;
      if ((wr & batch_q[i].rd) != 0) war_c = 1'b1;
    end
    if (raw_c || waw_c || war_c) begin
      exp_hits++;
      if (raw_c) exp_raw++;
      if (waw_c) exp_waw++;
      if (war_c) exp_war++;
    end else begin
      t.id = id;
      t.rd = rd;
      t.wr = wr;
      batch_q.push_back(t);
      exp_q.push_back(t);
      if (batch_q.size() == BATCH) begin
        close_q.push_back(BATCH);
        batch_q.delete();
      end
    end
  endfunction

  function automatic void modelFlush();
    if (batch_q.size() > 0) begin
      close_q.push_back(batch_q.size());
      batch_q.delete();
    end
  endfunction

  task automatic checkCounters();
    checkOutput("filter_hits", filter_hits, exp_hits);
`ifdef FILTER_CONFLICT_STATS_EN
    checkOutput("raw_hits", raw_hits, exp_raw);
    checkOutput("waw_hits", waw_hits, exp_waw);
    checkOutput("war_hits", war_hits, exp_war);
`endif
  endtask

  task automatic waitReady(input string name);
    int t = 0;
    while (!s_axis_tready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_axis_tready) reportTimeout(name);
  endtask

  // Offer one transaction, record its predicted fate, and wait until the
  // engine is idle again.
  task automatic applyStimulus(input logic [63:0] id, input logic [DEPS-1:0] rd,
                               input logic [DEPS-1:0] wr);
    @(negedge clk);
    s_axis_tdata_owner_programID    = id;
    s_axis_tdata_read_dependencies  = rd;
    s_axis_tdata_write_dependencies = wr;
    s_axis_tvalid                   = 1'b1;
    waitReady("accept");
    if (!s_axis_tready) begin
      s_axis_tvalid = 1'b0;
      return;
    end
    modelTxn(id, rd, wr);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    waitReady("complete");
    checkCounters();
  endtask

  task automatic applyFlush();
    @(negedge clk);
    batch_flush = 1'b1;
    modelFlush();
    @(negedge clk);
    batch_flush = 1'b0;
    waitReady("flush_done");
  endtask

  // Downstream ready, changed just after the rising edge so it is stable at
  // every sampling point.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready)      m_axis_tready = 1'b0;
      else if (rand_ready) m_axis_tready = ($urandom_range(0, 3) != 0);
      else                 m_axis_tready = 1'b1;
    end
  end

  // Monitor: compare every forwarded transaction and every batch close.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output_id", m_axis_tdata_owner_programID, 64'h0);
          n_fail += (m_axis_tdata_owner_programID == 64'h0) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          checkOutput("out_id", m_axis_tdata_owner_programID, e.id);
          checkOutput("out_rd", m_axis_tdata_read_dependencies, e.rd);
          checkOutput("out_wr", m_axis_tdata_write_dependencies, e.wr);
        end
      end
      if (!rst && batch_closed) begin
        if (close_q.size() == 0) begin
          reportTimeout("unexpected_batch_closed");
        end else begin
          checkOutput("batch_size", batch_size, close_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [63:0] rid;
    logic [7:0]  rrd;
    logic [7:0]  rwr;
    int          t;
    rst                             = 1'b1;
    s_axis_tvalid                   = 1'b0;
    s_axis_tdata_owner_programID    = '0;
    s_axis_tdata_read_dependencies  = '0;
    s_axis_tdata_write_dependencies = '0;
    ext_read_dependencies           = '0;
    ext_write_dependencies          = '0;
    batch_flush                     = 1'b0;

    // Reset held for two cycles: all outputs zero, ready afterwards.
    repeat (2) @(negedge clk);
    checkOutput("rst_m_tvalid", m_axis_tvalid, 0);
    checkOutput("rst_m_id", m_axis_tdata_owner_programID, 0);
    checkOutput("rst_closed", batch_closed, 0);
    checkOutput("rst_batch_size", batch_size, 0);
    checkOutput("rst_filter_hits", filter_hits, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_s_tready", s_axis_tready, 1);
    clearModel();

    // Read-after-write inside a batch is dropped.
    applyStimulus(64'h1, 8'h01, 8'h02);
    applyStimulus(64'h2, 8'h02, 8'h00);
    checkOutput("raw_drop_hits", filter_hits, 1);
    applyFlush();

    // External write lock blocks a write to the same bit.
    ext_write_dependencies = 8'h10;
    applyStimulus(64'h3, 8'h00, 8'h10);
    checkOutput("waw_drop_hits", filter_hits, 2);
    ext_write_dependencies = 8'h00;

    // Two disjoint writes fill a batch; the next write to bit 0 starts fresh.
    applyStimulus(64'h4, 8'h00, 8'h01);
    applyStimulus(64'h5, 8'h00, 8'h02);
    applyStimulus(64'h6, 8'h00, 8'h01);
    applyFlush();

    // Flush with an empty batch: no pulse, ready back after one busy cycle.
    @(negedge clk);
    batch_flush = 1'b1;
    @(negedge clk);
    batch_flush = 1'b0;
    checkOutput("empty_flush_busy", s_axis_tready, 0);
    @(negedge clk);
    checkOutput("empty_flush_ready", s_axis_tready, 1);
    checkOutput("empty_flush_no_pulse", batch_closed, 0);

    // Back-pressure for five cycles holds the output stable.
    hold_ready = 1'b1;
    fork
      applyStimulus(64'h77, 8'h00, 8'h40);
      begin
        t = 0;
        while (!m_axis_tvalid && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (!m_axis_tvalid) reportTimeout("stall_tvalid");
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall_tvalid", m_axis_tvalid, 1);
          checkOutput("stall_id", m_axis_tdata_owner_programID, 64'h77);
          checkOutput("stall_wr", m_axis_tdata_write_dependencies, 8'h40);
          checkOutput("stall_s_tready", s_axis_tready, 0);
        end
        hold_ready = 1'b0;
      end
    join
    checkOutput("stall_released", m_axis_tvalid, 0);
    applyFlush();

    // Reset while a forwarded transaction waits discards it and its locks.
    hold_ready = 1'b1;
    @(negedge clk);
    s_axis_tdata_owner_programID    = 64'h99;
    s_axis_tdata_read_dependencies  = 8'h00;
    s_axis_tdata_write_dependencies = 8'h08;
    s_axis_tvalid                   = 1'b1;
    waitReady("midrst_accept");
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    t = 0;
    while (!m_axis_tvalid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!m_axis_tvalid) reportTimeout("midrst_tvalid");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clearModel();
    checkOutput("midrst_m_tvalid", m_axis_tvalid, 0);
    checkOutput("midrst_s_tready", s_axis_tready, 1);
    hold_ready = 1'b0;
    applyStimulus(64'h9A, 8'h00, 8'h08);
    applyFlush();

    // Randomised traffic with random back-pressure and occasional flushes.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) applyFlush();
      ext_read_dependencies  = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
      ext_write_dependencies = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
      rid = {32'($urandom), 32'(i)};
      rrd = 8'($urandom & $urandom);
      rwr = 8'($urandom & $urandom & $urandom);
      applyStimulus(rid, rrd, rwr);
    end
    rand_ready = 1'b0;
    ext_read_dependencies  = '0;
    ext_write_dependencies = '0;
    applyFlush();
    repeat (5) @(negedge clk);
    checkOutput("pending_outputs", exp_q.size(), 0);
    checkOutput("pending_closes", close_q.size(), 0);
    checkCounters();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no completion, required completion");
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/batch_filter_engine.md
BATCH_FILTER_ENGINE -- requirements
Module: batch_filter_engine

Interface
REQ-001 SHALL have parameter MAX_DEPENDENCIES, default 1024: width of read/write dependency bitmaps.
REQ-002 SHALL have parameter MAX_BATCH_SIZE, default 16, legal range 1..255: accepted transactions per batch before auto-close.
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  sync active-high reset
- s_axis_tvalid  in  1  input transaction valid
- s_axis_tready  out  1  ready, combinational: (state==IDLE) && !flush_pending
- s_axis_tdata_owner_programID  in  64  transaction ID
- s_axis_tdata_read_dependencies  in  MAX_DEPENDENCIES  read bitmap
- s_axis_tdata_write_dependencies  in  MAX_DEPENDENCIES  write bitmap
- m_axis_tvalid  out  1  forwarded transaction valid
- m_axis_tready  in  1  downstream ready
- m_axis_tdata_owner_programID / _read_dependencies / _write_dependencies  out  64 / MAX / MAX  forwarded transaction
- ext_read_dependencies  in  MAX_DEPENDENCIES  externally held read locks
- ext_write_dependencies  in  MAX_DEPENDENCIES  externally held write locks
- batch_flush  in  1  request to close the current batch
- batch_closed  out  1  one-cycle pulse on batch close
- batch_size  out  8  transaction count of the last closed batch
- filter_hits  out  32  dropped-transaction count

Function
REQ-005 SHALL keep accumulators acc_rd/acc_wr (OR of all accepted bitmaps in the current batch) and batch_count.
REQ-006 SHALL form eff_rd = acc_rd | ext_read_dependencies and eff_wr = acc_wr | ext_write_dependencies; conflict types:
- RAW = |(rd & eff_wr)
- WAW = |(wr & eff_wr)
- WAR = |(wr & eff_rd)
REQ-007 SHALL implement FSM IDLE -> CHECK -> (IDLE | OUTPUT), OUTPUT -> (IDLE | CLOSE), IDLE -> CLOSE, CLOSE -> IDLE.
REQ-008 In IDLE, on s_axis handshake, SHALL latch ID and bitmaps and go to CHECK.
REQ-009 In CHECK with any conflict, SHALL drop the transaction, increment filter_hits (saturating at 0xFFFFFFFF), and go to IDLE; no m_axis activity.
REQ-010 In CHECK without conflict, SHALL:
- load the m_axis data registers and set m_axis_tvalid;
- OR the bitmaps into acc_rd/acc_wr;
- increment batch_count;
- go to OUTPUT.
Latency is 2 cycles from input handshake to m_axis_tvalid.
REQ-011 In OUTPUT, m_axis data SHALL stay stable while m_axis_tvalid=1 and m_axis_tready=0. On handshake it SHALL clear m_axis_tvalid, then go to CLOSE if batch_count==MAX_BATCH_SIZE, else IDLE.
REQ-012 batch_flush=1 in any state SHALL set sticky flush_pending. In IDLE with flush_pending: if batch_count>0, go to CLOSE; otherwise clear flush_pending with no pulse.
REQ-013 In CLOSE, for one cycle, SHALL:
- pulse batch_closed=1;
- set batch_size=batch_count;
- clear batch_count, acc_rd, acc_wr and flush_pending;
- go to IDLE.
REQ-014 Accepted transactions SHALL be checked against all earlier accepted transactions in the same batch (intra-batch filtering).
REQ-015 Peak throughput SHALL be one transaction per 3 cycles.

Reset
REQ-016 rst=1 SHALL force all of the following to zero: state (IDLE), m_axis_tvalid, m_axis data, accumulators, batch_count, flush_pending, batch_closed, batch_size, filter_hits and stats counters.
REQ-017 rst mid-OUTPUT SHALL discard the pending transaction; s_axis_tready=1 the first cycle after rst deasserts.

Configuration
REQ-018 With FILTER_CONFLICT_STATS_EN defined, SHALL add outputs raw_hits, waw_hits, war_hits (32 each, saturating). Each increments on a dropped transaction with that conflict type; several may increment in the same cycle.
REQ-019 Without FILTER_CONFLICT_STATS_EN, those ports and counters SHALL be absent; all other behaviour is unchanged.

Verification (MAX_DEPENDENCIES=8, MAX_BATCH_SIZE=2)
REQ-020 Reset: rst high for 2 cycles -> all outputs 0; s_axis_tready=1 after release.
REQ-021 Txn 0x1 (rd 0x01, wr 0x02) accepted, then txn 0x2 (rd 0x02) -> 0x2 dropped, filter_hits=1, raw_hits=1 if stats enabled.
REQ-022 ext_write_dependencies=0x10, txn wr 0x10 -> dropped, waw_hits=1; no m_axis_tvalid.
REQ-023 Txns wr 0x01 then wr 0x02 -> both forwarded; batch_closed pulse with batch_size=2; next txn wr 0x01 -> forwarded.
REQ-024 m_axis_tready low for 5 cycles -> m_axis data and tvalid stable, s_axis_tready=0; release -> single transfer.
REQ-025 batch_flush with batch_count=1 -> batch_closed, batch_size=1. batch_flush with batch_count=0 -> no pulse, s_axis_tready returns to 1 the next cycle.
